// File: rtl/bus_mon_pkg.sv
// Shared types and constants for the 6502 bus monitor.
package bus_mon_pkg;

    // Trap detector states
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        TRAPPED
    } mon_state_t;

    // Bit positions inside err
    localparam int unsigned ERR_WE_NOMEN     = 0;
    localparam int unsigned ERR_IREAD_NOMEN  = 1;
    localparam int unsigned ERR_IREAD_WE     = 2;
    localparam int unsigned ERR_SYNC_NOIREAD = 3;
    localparam int unsigned ERR_W            = 4;

    // Width of the repeat counter; holds TRAP_CNT up to 15
    localparam int unsigned REP_W = 4;

endpackage

// File: rtl/bus_mon_watch.sv
// One write-watch channel: address compare, value capture, change pulse.
module bus_mon_watch #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          rdy,
    input  logic          men,
    input  logic          we,
    input  logic [AW-1:0] ab,
    input  logic [DW-1:0] dout,
    input  logic [AW-1:0] watch_addr,
    output logic [DW-1:0] watch_val,
    output logic          watch_hit
);

    logic match;

    // Qualified store to the watched address
    assign match = rdy & men & we & (ab == watch_addr);

    // Capture the stored value; pulse only when it actually changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            watch_val <= '0;
            watch_hit <= 1'b0;
        end else if (clr) begin
            watch_val <= '0;
            watch_hit <= 1'b0;
        end else begin
            watch_hit <= 1'b0;
            if (match) begin
                watch_val <= dout;
                watch_hit <= (dout != watch_val);
            end
        end
    end

endmodule

// File: rtl/bus_monitor_6502.sv
// Passive monitor for the 6502 memory interface: counters, sticky protocol
// error flags, write-watch channels and a jump-to-self trap detector.
// Optional feature: define BUS_MON_TRAP_EN to build the trap detector.
module bus_monitor_6502
    import bus_mon_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 8,
    parameter int unsigned NWATCH   = 2,
    parameter int unsigned CNTW     = 32,
    parameter int unsigned TRAP_CNT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 rdy,
    input  logic                 men,
    input  logic                 we,
    input  logic                 sync,
    input  logic                 iread,
    input  logic [AW-1:0]        ab,
    input  logic [DW-1:0]        dout,
    input  logic [NWATCH*AW-1:0] watch_addr,
    output logic [CNTW-1:0]      cycle_cnt,
    output logic [CNTW-1:0]      instr_cnt,
    output logic [CNTW-1:0]      nomen_cnt,
    output logic [NWATCH*DW-1:0] watch_val,
    output logic [NWATCH-1:0]    watch_hit,
    output logic [ERR_W-1:0]     err,
    output logic                 trap,
    output logic [AW-1:0]        trap_pc
);

    logic             freeze;
    logic [ERR_W-1:0] err_set;

`ifdef BUS_MON_TRAP_EN
    mon_state_t        state;
    logic [AW-1:0]     last_pc;
    logic [REP_W-1:0]  rep;
    logic [REP_W-1:0]  rep_inc;

    assign rep_inc = rep + REP_W'(1);

    // Track the run of identical fetch addresses; latch the trap when it hits TRAP_CNT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_pc <= '0;
            rep     <= '0;
            trap    <= 1'b0;
            trap_pc <= '0;
        end else if (clr) begin
            state   <= IDLE;
            last_pc <= '0;
            rep     <= '0;
            trap    <= 1'b0;
            trap_pc <= '0;
        end else if (rdy && sync) begin
            case (state)
                IDLE: begin
                    last_pc <= ab;
                    rep     <= REP_W'(1);
                    state   <= RUN;
                end
                RUN: begin
                    if (ab == last_pc) begin
                        rep <= rep_inc;
                        if (rep_inc == REP_W'(TRAP_CNT)) begin
                            state   <= TRAPPED;
                            trap    <= 1'b1;
                            trap_pc <= last_pc;
                        end
                    end else begin
                        last_pc <= ab;
                        rep     <= REP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic unused_trap_cnt;

    assign unused_trap_cnt = ^TRAP_CNT;
    assign trap            = 1'b0;
    assign trap_pc         = '0;
`endif

    assign freeze = trap;

    // Saturating event counters, held once a trap is flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            nomen_cnt <= '0;
        end else if (clr) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            nomen_cnt <= '0;
        end else if (rdy && !freeze) begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNTW'(1);
            if (sync && (instr_cnt != '1)) instr_cnt <= instr_cnt + CNTW'(1);
            if (!men && (nomen_cnt != '1)) nomen_cnt <= nomen_cnt + CNTW'(1);
        end
    end

    // Protocol violations seen on the current cycle
    always_comb begin
        err_set                   = '0;
        err_set[ERR_WE_NOMEN]     = we & ~men;
        err_set[ERR_IREAD_NOMEN]  = iread & ~men;
        err_set[ERR_IREAD_WE]     = iread & we;
        err_set[ERR_SYNC_NOIREAD] = men & sync & ~iread;
    end

    // Sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else if (clr) begin
            err <= '0;
        end else if (rdy) begin
            err <= err | err_set;
        end
    end

    // Independent watch channels
    for (genvar i = 0; i < NWATCH; i++) begin : g_watch
        bus_mon_watch #(
            .AW(AW),
            .DW(DW)
        ) u_watch (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .rdy        (rdy),
            .men        (men),
            .we         (we),
            .ab         (ab),
            .dout       (dout),
            .watch_addr (watch_addr[i*AW +: AW]),
            .watch_val  (watch_val[i*DW +: DW]),
            .watch_hit  (watch_hit[i])
        );
    end

endmodule

// File: tb/tb_bus_monitor_6502.sv
// Self-checking bench for bus_monitor_6502 (directed steps plus random traffic
// against a behavioural model). Expectations follow BUS_MON_TRAP_EN if defined.
module tb_bus_monitor_6502;

    localparam int unsigned AW       = 16;
    localparam int unsigned DW       = 8;
    localparam int unsigned NWATCH   = 2;
    localparam int unsigned CNTW     = 16;
    localparam int unsigned TRAP_CNT = 3;
    localparam int          MAXC     = 65535;
`ifdef BUS_MON_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 clr;
    logic                 rdy;
    logic                 men;
    logic                 we;
    logic                 sync;
    logic                 iread;
    logic [AW-1:0]        ab;
    logic [DW-1:0]        dout;
    logic [NWATCH*AW-1:0] watch_addr;
    logic [CNTW-1:0]      cycle_cnt;
    logic [CNTW-1:0]      instr_cnt;
    logic [CNTW-1:0]      nomen_cnt;
    logic [NWATCH*DW-1:0] watch_val;
    logic [NWATCH-1:0]    watch_hit;
    logic [3:0]           err;
    logic                 trap;
    logic [AW-1:0]        trap_pc;

    bus_monitor_6502 #(
        .AW(AW), .DW(DW), .NWATCH(NWATCH), .CNTW(CNTW), .TRAP_CNT(TRAP_CNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .rdy(rdy), .men(men), .we(we),
        .sync(sync), .iread(iread), .ab(ab), .dout(dout), .watch_addr(watch_addr),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .nomen_cnt(nomen_cnt),
        .watch_val(watch_val), .watch_hit(watch_hit), .err(err),
        .trap(trap), .trap_pc(trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    int          m_cycle, m_instr, m_nomen;
    logic [3:0]  m_err;
    logic [7:0]  m_val [NWATCH];
    logic [NWATCH-1:0] m_hit;
    logic        m_trap;
    logic [15:0] m_trap_pc;
    logic [15:0] fetches [$];

    function automatic int sat_inc(input int c);
        return (c >= MAXC) ? MAXC : c + 1;
    endfunction

    task automatic model_reset();
        m_cycle = 0; m_instr = 0; m_nomen = 0;
        m_err = '0; m_hit = '0; m_trap = 1'b0; m_trap_pc = '0;
        for (int i = 0; i < NWATCH; i++) m_val[i] = '0;
        fetches.delete();
    endtask

    // Behavioural view of one clock edge given the inputs currently applied
    task automatic model_update();
        bit same;
        if (clr) begin
            model_reset();
        end else begin
            m_hit = '0;
            if (rdy) begin
                if (!m_trap) begin
                    m_cycle = sat_inc(m_cycle);
                    if (sync) m_instr = sat_inc(m_instr);
                    if (!men) m_nomen = sat_inc(m_nomen);
                end
                if (we && !men)          m_err[0] = 1'b1;
                if (iread && !men)       m_err[1] = 1'b1;
                if (iread && we)         m_err[2] = 1'b1;
                if (men && sync && !iread) m_err[3] = 1'b1;
                for (int i = 0; i < NWATCH; i++) begin
                    if (men && we && ab == watch_addr[i*AW +: AW]) begin
                        m_hit[i] = (dout != m_val[i]);
                        m_val[i] = dout;
                    end
                end
                if (TRAP_EN && !m_trap && sync) begin
                    fetches.push_back(ab);
                    if (fetches.size() > TRAP_CNT) void'(fetches.pop_front());
                    if (fetches.size() == TRAP_CNT) begin
                        same = 1'b1;
                        foreach (fetches[k]) if (fetches[k] != ab) same = 1'b0;
                        if (same) begin
                            m_trap    = 1'b1;
                            m_trap_pc = ab;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [NWATCH*DW-1:0] ev;
        for (int i = 0; i < NWATCH; i++) ev[i*DW +: DW] = m_val[i];
        chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cycle));
        chk("instr_cnt", 32'(instr_cnt), 32'(m_instr));
        chk("nomen_cnt", 32'(nomen_cnt), 32'(m_nomen));
        chk("err", 32'(err), 32'(m_err));
        chk("watch_val", 32'(watch_val), 32'(ev));
        chk("watch_hit", 32'(watch_hit), 32'(m_hit));
        chk("trap", 32'(trap), 32'(m_trap));
        chk("trap_pc", 32'(trap_pc), 32'(m_trap_pc));
    endtask

    task automatic drive(input logic r, input logic m, input logic w, input logic s,
                         input logic ir, input logic [15:0] a, input logic [7:0] d,
                         input logic c);
        rdy = r; men = m; we = w; sync = s; iread = ir; ab = a; dout = d; clr = c;
    endtask

    // Apply inputs, clock once, update model, compare everything
    task automatic step(input logic r, input logic m, input logic w, input logic s,
                        input logic ir, input logic [15:0] a, input logic [7:0] d,
                        input logic c);
        drive(r, m, w, s, ir, a, d, c);
        @(posedge clk);
        #1;
        model_update();
        check_all();
    endtask

    task automatic do_clr();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0200, 8'h55, 1'b1);
    endtask

    initial begin
        logic [15:0] trap_seq [6];
        logic [15:0] pool [4];
        logic [15:0] a;
        trap_seq = '{16'h3469, 16'h3469, 16'h3470, 16'h3469, 16'h3469, 16'h3469};
        pool     = '{16'h0200, 16'h0201, 16'h3469, 16'h3470};

        rst_n = 1'b0;
        watch_addr = {16'h0200, 16'h0200};
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        model_reset();
        #3;
        check_all();
        #9;
        rst_n = 1'b1;

        // Counting: 10 qualified cycles, sync every 2nd, then 5 stalled cycles
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 1'b0, (i % 2) == 1, (i % 2) == 1, 16'(16'h1000 + i), 8'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b0, (i % 2) == 1, 1'b1, 16'h1000, 8'h0, 1'b0);
        chk("count_cycle10", 32'(cycle_cnt), 32'd10);
        chk("count_instr5", 32'(instr_cnt), 32'd5);
        chk("count_nomen0", 32'(nomen_cnt), 32'd0);

        // Two channels on the same address
        do_clr();
        watch_addr = {16'h0200, 16'h0200};
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 8'h01, 1'b0);
        chk("watch_hit_w1", 32'(watch_hit), 32'h3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 8'h01, 1'b0);
        chk("watch_hit_w2", 32'(watch_hit), 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 8'h02, 1'b0);
        chk("watch_hit_w3", 32'(watch_hit), 32'h3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("watch_hit_idle", 32'(watch_hit), 32'h0);
        chk("watch_val_final", 32'(watch_val), 32'h0202);

        // Sticky error flags
        do_clr();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
        chk("err_0101", 32'(err), 32'h5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("err_sticky", 32'(err), 32'h5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("err_clr", 32'(err), 32'h0);

        // Jump-to-self trap
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, trap_seq[i], 8'h00, 1'b0);
        chk("trap_set", 32'(trap), 32'(TRAP_EN));
        chk("trap_pc", 32'(trap_pc), TRAP_EN ? 32'h3469 : 32'h0);
        chk("trap_instr6", 32'(instr_cnt), 32'd6);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3469, 8'h00, 1'b0);
        chk("trap_instr_after", 32'(instr_cnt), TRAP_EN ? 32'd6 : 32'd9);
        chk("trap_cycle_after", 32'(cycle_cnt), TRAP_EN ? 32'd6 : 32'd9);

        // Saturation
        do_clr();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            model_update();
        end
        check_all();
        chk("sat_cycle", 32'(cycle_cnt), 32'hFFFF);

        // Random traffic against the model
        do_clr();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 3)
                watch_addr = {pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)]};
            a = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 3)] : 16'($urandom);
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a,
                 8'($urandom_range(0, 3)), $urandom_range(0, 199) == 0);
            if (n == 1500) begin
                rst_n = 1'b0;
                #2;
                model_reset();
                check_all();
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
